datapath_gearbox_fifo: RTL and testbench

Parametrised width-converting FIFO for the driver datapath. It packs BEATS consecutive IN_W-bit input beats into one OUT_W-bit word and stores it in a DEPTH-word buffer. It releases words on a runtime-programmable read tick. It supersedes the fixed 128→192, divide-by-30 datapath FIFO and adds correct occupancy, a programmable threshold, flush and sticky error flags.

---
 rtl/datapath_pkg.sv | 27 ++
 rtl/datapath_gearbox_fifo_if.sv | 25 ++
 rtl/rd_tick_gen.sv | 33 +++
 rtl/datapath_gearbox_fifo.sv | 151 +++++++++++++++
 tb/tb_datapath_gearbox_fifo.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/datapath_pkg.sv
// Shared constants and width helpers for the driver datapath blocks.
// Gearbox geometry is derived here so every user computes it the same way.
package datapath_pkg;

  localparam int DEF_IN_W   = 128;
  localparam int DEF_OUT_W  = 192;
  localparam int DEF_DEPTH  = 1024;
  localparam int DEF_DIV_W  = 6;
  localparam int DEF_RD_DIV = 29;

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

  function automatic int beats_f(input int out_w, input int in_w);
    return ceil_div(out_w, in_w);
  endfunction

  // Width of the slice taken from the final beat of a word.
  function automatic int tail_w_f(input int out_w, input int in_w);
    return out_w - (beats_f(out_w, in_w) - 1) * in_w;
  endfunction

  localparam int DEF_BEATS  = beats_f(DEF_OUT_W, DEF_IN_W);
  localparam int DEF_TAIL_W = tail_w_f(DEF_OUT_W, DEF_IN_W);

endpackage

// File: rtl/datapath_gearbox_fifo_if.sv
// Beat-in / word-out handshake bundle of the gearbox FIFO.
// The master side produces beats and read requests; the slave is the FIFO.
interface datapath_gearbox_fifo_if #(
  parameter int IN_W  = 128,
  parameter int OUT_W = 192
);

  logic             wr;
  logic [IN_W-1:0]  data_in;
  logic             wr_ready;
  logic             rd;
  logic [OUT_W-1:0] data_out;
  logic             data_valid;

  modport master (
    output wr, data_in, rd,
    input  wr_ready, data_out, data_valid
  );

  modport slave (
    input  wr, data_in, rd,
    output wr_ready, data_out, data_valid
  );

endinterface

// File: rtl/rd_tick_gen.sv
// Programmable rate tick: one tick every div+1 cycles, free running.
// The >= compare lets div shrink at runtime without a long wrap-around.
module rd_tick_gen #(
  parameter int DIV_W = 6
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             tick
);

  logic [DIV_W-1:0] tick_cnt_q;
  logic [DIV_W-1:0] tick_cnt_d;

  assign tick = (tick_cnt_q >= div);

  always_comb begin
    tick_cnt_d = tick_cnt_q + 1'b1;
    if (clr || tick) begin
      tick_cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

endmodule

// File: rtl/datapath_gearbox_fifo.sv
// Width-converting FIFO: packs BEATS input beats MSB-first into one word,
// buffers DEPTH words and releases them on a programmable read tick.
module datapath_gearbox_fifo
  import datapath_pkg::*;
#(
  parameter int IN_W  = DEF_IN_W,
  parameter int OUT_W = DEF_OUT_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int DIV_W = DEF_DIV_W
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic [DIV_W-1:0]           rd_div,
  input  logic [$clog2(DEPTH):0]     thr_level,
  datapath_gearbox_fifo_if.slave     bus,
  output logic [$clog2(DEPTH):0]     data_count,
  output logic                       full,
  output logic                       empty,
  output logic                       threshold,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int AW     = $clog2(DEPTH);
  localparam int BEATS  = beats_f(OUT_W, IN_W);
  localparam int TAIL_W = tail_w_f(OUT_W, IN_W);
  localparam int STG_W  = (BEATS - 1) * IN_W;
  localparam int BCW    = (BEATS > 2) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  logic [OUT_W-1:0] mem [DEPTH];

  logic [AW:0]       w_ptr_q, w_ptr_d;
  logic [AW:0]       r_ptr_q, r_ptr_d;
  logic [BCW-1:0]    beat_cnt_q, beat_cnt_d;
  logic [STG_W-1:0]  staging_q, staging_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;
  logic              data_valid_q, data_valid_d;
  logic [OUT_W-1:0]  data_out_q;

  logic              tick;
  logic              accept;
  logic              beat_last;
  logic              commit;
  logic              rd_en;

  rd_tick_gen #(.DIV_W(DIV_W)) u_rd_tick_gen (
    .clk  (clk),
    .rstn (rstn),
    .clr  (flush),
    .div  (rd_div),
    .tick (tick)
  );

  assign empty      = (w_ptr_q == r_ptr_q);
  assign full       = (w_ptr_q[AW] != r_ptr_q[AW]) && (w_ptr_q[AW-1:0] == r_ptr_q[AW-1:0]);
  assign data_count = w_ptr_q - r_ptr_q;
  assign threshold  = (data_count >= thr_level);
  assign overflow   = overflow_q;
  assign underflow  = underflow_q;

  // A word in progress always owns a free slot, so only its first beat waits on full.
  assign bus.wr_ready   = (beat_cnt_q != '0) | ~full;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;

  assign accept    = bus.wr & bus.wr_ready & ~flush;
  assign beat_last = (beat_cnt_q == LAST_BEAT);
  assign commit    = accept & beat_last;
  assign rd_en     = bus.rd & tick & ~empty & ~flush;

  always_comb begin
    w_ptr_d      = w_ptr_q;
    r_ptr_d      = r_ptr_q;
    beat_cnt_d   = beat_cnt_q;
    staging_d    = staging_q;
    overflow_d   = overflow_q;
    underflow_d  = underflow_q;
    data_valid_d = 1'b0;
    if (flush) begin
      w_ptr_d     = '0;
      r_ptr_d     = '0;
      beat_cnt_d  = '0;
      overflow_d  = 1'b0;
      underflow_d = 1'b0;
    end else begin
      if (accept) begin
        if (beat_last) begin
          beat_cnt_d = '0;
        end else begin
          beat_cnt_d = beat_cnt_q + 1'b1;
          // Shifting left keeps beat 0 at the top of the staging register.
          staging_d  = STG_W'({staging_q, bus.data_in});
        end
      end
      if (commit) begin
        w_ptr_d = w_ptr_q + 1'b1;
      end
      if (rd_en) begin
        r_ptr_d      = r_ptr_q + 1'b1;
        data_valid_d = 1'b1;
      end
      if (bus.wr && !bus.wr_ready) begin
        overflow_d = 1'b1;
      end
      if (bus.rd && tick && empty) begin
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      w_ptr_q      <= '0;
      r_ptr_q      <= '0;
      beat_cnt_q   <= '0;
      overflow_q   <= 1'b0;
      underflow_q  <= 1'b0;
      data_valid_q <= 1'b0;
    end else begin
      w_ptr_q      <= w_ptr_d;
      r_ptr_q      <= r_ptr_d;
      beat_cnt_q   <= beat_cnt_d;
      overflow_q   <= overflow_d;
      underflow_q  <= underflow_d;
      data_valid_q <= data_valid_d;
    end
  end

  always_ff @(posedge clk) begin
    staging_q <= staging_d;
  end

  // Single write port and registered single read port keep this block-RAM shaped.
  always_ff @(posedge clk) begin
    if (commit) begin
      mem[w_ptr_q[AW-1:0]] <= {staging_q, bus.data_in[TAIL_W-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      data_out_q <= '0;
    end else if (rd_en) begin
      data_out_q <= mem[r_ptr_q[AW-1:0]];
    end
  end

endmodule

// File: tb/tb_datapath_gearbox_fifo.sv
// Directed bench for datapath_gearbox_fifo at default geometry (128 -> 192, 1024 words).
// A vector table covers packing; hand sequences cover fill, rate, flush and threshold.
module tb_datapath_gearbox_fifo;
  import datapath_pkg::*;

  localparam int IN_W  = DEF_IN_W;
  localparam int OUT_W = DEF_OUT_W;
  localparam int DEPTH = DEF_DEPTH;
  localparam int DIV_W = DEF_DIV_W;
  localparam int AW    = $clog2(DEPTH);

  logic             clk = 1'b0;
  logic             rstn;
  logic             flush;
  logic [DIV_W-1:0] rd_div;
  logic [AW:0]      thr_level;
  logic [AW:0]      data_count;
  logic             full, empty, threshold, overflow, underflow;

  datapath_gearbox_fifo_if #(.IN_W(IN_W), .OUT_W(OUT_W)) bus ();

  datapath_gearbox_fifo #(
    .IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH), .DIV_W(DIV_W)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .flush      (flush),
    .rd_div     (rd_div),
    .thr_level  (thr_level),
    .bus        (bus.slave),
    .data_count (data_count),
    .full       (full),
    .empty      (empty),
    .threshold  (threshold),
    .overflow   (overflow),
    .underflow  (underflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] b0;
    logic [127:0] b1;
    logic [191:0] word;
  } vec_t;

  vec_t vecs [4];
  int   total  = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [191:0] act, input logic [191:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_beat(input logic [127:0] b);
    bus.wr      = 1'b1;
    bus.data_in = b;
    tick();
    bus.wr      = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic read_one();
    bus.rd = 1'b1;
    tick();
    bus.rd = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_data_out"},   bus.data_out,   192'd0);
    check({tag, "_data_valid"}, bus.data_valid, 1'b0);
    check({tag, "_empty"},      empty,          1'b1);
    check({tag, "_full"},       full,           1'b0);
    check({tag, "_count"},      data_count,     0);
    check({tag, "_wr_ready"},   bus.wr_ready,   1'b1);
    check({tag, "_overflow"},   overflow,       1'b0);
    check({tag, "_underflow"},  underflow,      1'b0);
    check({tag, "_threshold"},  threshold,      1'b0);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bit got;
    int cyc;
    int nvalid;
    int last;
    bit cnt_ok;
    bit flags_ok;

    vecs[0] = '{128'h00112233_44556677_8899AABB_CCDDEEFF, 128'hFFFFFFFF_FFFFFFFF_DEADBEEF_CAFEF00D,
                192'h00112233_44556677_8899AABB_CCDDEEFF_DEADBEEF_CAFEF00D};
    vecs[1] = '{128'h0, {128{1'b1}},
                192'h00000000_00000000_00000000_00000000_FFFFFFFF_FFFFFFFF};
    vecs[2] = '{{128{1'b1}}, 128'h12345678_9ABCDEF0_00000000_00000001,
                192'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_00000000_00000001};
    vecs[3] = '{128'h80000000_00000000_00000000_00000001, 128'h0000000F_00000000_80000000_00000000,
                192'h80000000_00000000_00000000_00000001_80000000_00000000};

    rstn        = 1'b0;
    flush       = 1'b0;
    bus.wr      = 1'b0;
    bus.rd      = 1'b0;
    bus.data_in = '0;
    rd_div      = DIV_W'(DEF_RD_DIV);
    thr_level   = 3;
    repeat (3) tick();
    check_reset_state("reset");
    rstn = 1'b1;

    // Pack with the default read pace; rd is raised once the word is committed.
    write_beat(vecs[0].b0);
    write_beat(vecs[0].b1);
    check("pack_empty", empty, 1'b0);
    check("pack_count", data_count, 1);
    bus.rd = 1'b1;
    got = 1'b0;
    cyc = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      tick();
      cyc++;
      if (bus.data_valid) got = 1'b1;
    end
    bus.rd = 1'b0;
    check("pack_valid_seen", got, 1'b1);
    check("pack_latency_le31", (cyc <= 31), 1'b1);
    check("pack_word", bus.data_out, vecs[0].word);
    tick();
    check("pack_valid_pulse", bus.data_valid, 1'b0);
    check("pack_no_underflow", underflow, 1'b0);

    // Table of packing vectors at full read rate.
    rd_div = '0;
    do_flush();
    for (int v = 0; v < 4; v++) begin
      write_beat(vecs[v].b0);
      write_beat(vecs[v].b1);
      read_one();
      check($sformatf("vec%0d_valid", v), bus.data_valid, 1'b1);
      check($sformatf("vec%0d_word", v), bus.data_out, vecs[v].word);
    end
    check("vec_empty_after", empty, 1'b1);
    check("vec_no_underflow", underflow, 1'b0);

    // Fill to capacity, then one extra beat.
    do_flush();
    for (int i = 0; i < 2048; i++) begin
      bus.wr      = 1'b1;
      bus.data_in = 128'(i);
      tick();
    end
    bus.wr = 1'b0;
    check("fill_full", full, 1'b1);
    check("fill_count", data_count, 1024);
    check("fill_wr_ready", bus.wr_ready, 1'b0);
    check("fill_no_overflow", overflow, 1'b0);
    write_beat(128'hBAD);
    check("fill_overflow", overflow, 1'b1);
    bus.rd = 1'b1;
    tick();
    check("fill_first_word", bus.data_out, {128'd0, 64'd1});
    repeat (9) tick();
    bus.rd = 1'b0;
    check("fill_overflow_sticky", overflow, 1'b1);
    check("fill_count_after_reads", data_count, 1014);

    // Rate and drain: four words, one read every fourth cycle.
    do_flush();
    rd_div = DIV_W'(3);
    for (int k = 0; k < 4; k++) begin
      write_beat(128'hA0 + 128'(k));
      write_beat(128'hB0 + 128'(k));
    end
    check("drain_count", data_count, 4);
    bus.rd = 1'b1;
    nvalid = 0;
    last   = 0;
    for (int c = 0; c < 40 && nvalid < 4; c++) begin
      tick();
      if (bus.data_valid) begin
        check($sformatf("drain_word%0d", nvalid), bus.data_out,
              {128'hA0 + 128'(nvalid), 64'hB0 + 64'(nvalid)});
        if (nvalid > 0) check($sformatf("drain_gap%0d", nvalid), c - last, 4);
        last = c;
        nvalid++;
      end
    end
    check("drain_n_words", nvalid, 4);
    check("drain_empty", empty, 1'b1);
    got = 1'b0;
    for (int c = 0; c < 6 && !got; c++) begin
      tick();
      if (underflow) got = 1'b1;
    end
    bus.rd = 1'b0;
    check("drain_underflow", got, 1'b1);

    // Partial word stays hidden; flush with a concurrent beat discards it.
    write_beat(128'h1111);
    check("partial_empty", empty, 1'b1);
    check("partial_count", data_count, 0);
    flush       = 1'b1;
    bus.wr      = 1'b1;
    bus.data_in = 128'h2222;
    tick();
    flush  = 1'b0;
    bus.wr = 1'b0;
    check("flush_underflow", underflow, 1'b0);
    check("flush_overflow", overflow, 1'b0);
    check("flush_empty", empty, 1'b1);
    check("flush_wr_ready", bus.wr_ready, 1'b1);
    rd_div = '0;
    write_beat(128'h01234567_89ABCDEF_FEDCBA98_76543210);
    check("flush_no_early_commit", data_count, 0);
    write_beat(128'hAAAAAAAA_BBBBBBBB_CCCCCCCC_DDDDDDDD);
    check("flush_fresh_count", data_count, 1);
    read_one();
    check("flush_fresh_word", bus.data_out,
          192'h01234567_89ABCDEF_FEDCBA98_76543210_CCCCCCCC_DDDDDDDD);

    // Commit and read on the same edge around a half-full buffer.
    do_flush();
    for (int i = 0; i < 1024; i++) begin
      bus.wr      = 1'b1;
      bus.data_in = 128'(i);
      tick();
    end
    bus.wr = 1'b0;
    check("simul_start_count", data_count, 512);
    cnt_ok   = 1'b1;
    flags_ok = 1'b1;
    for (int j = 0; j < 40; j++) begin
      bus.wr      = 1'b1;
      bus.data_in = 128'(j);
      bus.rd      = (j % 2 == 1);
      tick();
      if (data_count != 512 && data_count != 513) cnt_ok = 1'b0;
      if (full || empty) flags_ok = 1'b0;
    end
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    check("simul_count_range", cnt_ok, 1'b1);
    check("simul_no_flag_toggle", flags_ok, 1'b1);
    check("simul_end_count", data_count, 512);

    // Threshold edges, then a reset in the middle of traffic.
    do_flush();
    thr_level = 3;
    for (int k = 0; k < 3; k++) begin
      write_beat(128'h10 + 128'(k));
      write_beat(128'h20 + 128'(k));
      check($sformatf("thr_after_word%0d", k + 1), threshold, (k == 2));
    end
    read_one();
    check("thr_after_read", threshold, 1'b0);
    check("thr_count_after_read", data_count, 2);
    check("thr_read_word", bus.data_out, {128'h10, 64'h20});
    rstn        = 1'b0;
    bus.wr      = 1'b1;
    bus.rd      = 1'b1;
    bus.data_in = 128'h3333;
    tick();
    check_reset_state("midreset");
    rstn   = 1'b1;
    bus.wr = 1'b0;
    bus.rd = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
